audio_rec_play_ctrl: RTL and testbench

- Parametrised record/playback sequencer between the audio codec controller handshake and a single-port synchronous sample RAM.
- Captures stereo samples, replicates each into REPEAT consecutive words to compensate for codec write-rate mismatch, and plays them back once or looped.
- Provides live passthrough when idle.
- Playback data leaves through dedicated output ports, so a downstream filter or equalizer can sit in the path.

---
 rtl/audio_rec_pkg.sv | 22 ++
 rtl/rd_lat_delay.sv | 27 ++
 rtl/audio_rec_play_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_audio_rec_play_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_rec_pkg.sv
// Shared definitions for the audio record/playback sequencer.
// State codes are visible on the state port for LEDs.
package audio_rec_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ADDR_W_DEF   = 16;
    localparam int STEREO_W_DEF = 2 * SAMPLE_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REC_WAIT   = 3'd1,
        S_REC_WRITE  = 3'd2,
        S_PLAY_WAIT  = 3'd3,
        S_PLAY_FETCH = 3'd4,
        S_PLAY_OUT   = 3'd5
    } state_t;

    function automatic int stereo_w(input int sample_w);
        return 2 * sample_w;
    endfunction

endpackage

// File: rtl/rd_lat_delay.sv
// Valid shift register that flags when RAM read data has arrived,
// RD_LAT cycles after a fetch is launched.
module rd_lat_delay #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic start,
    output logic valid
);

    logic [RD_LAT-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | RD_LAT'(start);
        end
    end

    assign valid = sr[RD_LAT-1];

endmodule

// File: rtl/audio_rec_play_ctrl.sv
// Record/playback sequencer between the codec handshake and a
// single-port sample RAM, with live passthrough while idle.
module audio_rec_play_ctrl
    import audio_rec_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int REPEAT   = 3,
    parameter int RD_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic                  passthrough,
    input  logic                  audio_in_available,
    input  logic                  audio_out_allowed,
    input  logic [SAMPLE_W-1:0]   left_in,
    input  logic [SAMPLE_W-1:0]   right_in,
    output logic                  read_audio_in,
    output logic                  write_audio_out,
    output logic [SAMPLE_W-1:0]   left_out,
    output logic [SAMPLE_W-1:0]   right_out,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [2*SAMPLE_W-1:0] mem_wdata,
    output logic                  mem_wren,
    input  logic [2*SAMPLE_W-1:0] mem_rdata,
    output logic [ADDR_W:0]       rec_len,
    output logic [2:0]            state
);

    localparam int WORD_W = stereo_w(SAMPLE_W);

    state_t              st_q, st_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W:0]     len_d;
    logic [WORD_W-1:0]   wdata_d;
    logic [SAMPLE_W-1:0] lo_d, ro_d;
    logic                wren_d, rd_d, wr_d;
    logic [2:0]          burst_q, burst_d;
    logic                stop_q, stop_d;
    logic                go, data_vld, in_play;

    assign go      = audio_in_available & audio_out_allowed;
    assign in_play = st_q inside {S_PLAY_WAIT, S_PLAY_FETCH, S_PLAY_OUT};
    assign state   = st_q;

    rd_lat_delay #(.RD_LAT(RD_LAT)) u_rd_lat (
        .clk   (clk),
        .rst   (rst),
        .clr   (st_q == S_IDLE),
        .start ((st_q == S_PLAY_WAIT) && go && !stop),
        .valid (data_vld)
    );

    always_comb begin
        st_d    = st_q;
        addr_d  = mem_addr;
        len_d   = rec_len;
        wdata_d = mem_wdata;
        lo_d    = left_out;
        ro_d    = right_out;
        wren_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        burst_d = burst_q;
        stop_d  = stop_q;
        unique case (st_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (rec_start) begin
                    st_d   = S_REC_WAIT;
                    addr_d = '0;
                    len_d  = '0;
                end else if (play_start && rec_len != '0) begin
                    st_d   = S_PLAY_WAIT;
                    addr_d = '0;
                end else if (passthrough) begin
                    // gate on the previous strobe so strobes never repeat
                    if (go && !read_audio_in && !write_audio_out) begin
                        rd_d = 1'b1;
                        wr_d = 1'b1;
                        lo_d = left_in;
                        ro_d = right_in;
                    end
                end else begin
                    lo_d = '0;
                    ro_d = '0;
                end
            end
            S_REC_WAIT: begin
                if (stop || stop_q) begin
                    st_d   = S_IDLE;
                    stop_d = 1'b0;
                end else if (go) begin
                    rd_d    = 1'b1;
                    wdata_d = {left_in, right_in};
                    wren_d  = 1'b1;
                    burst_d = '0;
                    st_d    = S_REC_WRITE;
                end
            end
            S_REC_WRITE: begin
                if (stop) stop_d = 1'b1;
                len_d = rec_len + (ADDR_W+1)'(1);
                if (&mem_addr) begin
                    st_d = S_IDLE;
                end else begin
                    addr_d = mem_addr + ADDR_W'(1);
                    if (burst_q == 3'(REPEAT - 1)) begin
                        st_d = S_REC_WAIT;
                    end else begin
                        wren_d  = 1'b1;
                        burst_d = burst_q + 3'd1;
                    end
                end
            end
            S_PLAY_WAIT: begin
                if (go) st_d = S_PLAY_FETCH;
            end
            S_PLAY_FETCH: begin
                if (data_vld) begin
                    {lo_d, ro_d} = mem_rdata;
                    st_d = S_PLAY_OUT;
                end
            end
            S_PLAY_OUT: begin
                rd_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = mem_addr + ADDR_W'(1);
                st_d   = S_PLAY_WAIT;
                if (({1'b0, mem_addr} + (ADDR_W+1)'(1)) == rec_len) begin
                    if (loop_en) addr_d = '0;
                    else         st_d   = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase
        if (stop && in_play) begin
            st_d = S_IDLE;
            rd_d = 1'b0;
            wr_d = 1'b0;
            if (!passthrough) begin
                lo_d = '0;
                ro_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q            <= S_IDLE;
            mem_addr        <= '0;
            rec_len         <= '0;
            mem_wdata       <= '0;
            mem_wren        <= 1'b0;
            read_audio_in   <= 1'b0;
            write_audio_out <= 1'b0;
            left_out        <= '0;
            right_out       <= '0;
            burst_q         <= '0;
            stop_q          <= 1'b0;
        end else begin
            st_q            <= st_d;
            mem_addr        <= addr_d;
            rec_len         <= len_d;
            mem_wdata       <= wdata_d;
            mem_wren        <= wren_d;
            read_audio_in   <= rd_d;
            write_audio_out <= wr_d;
            left_out        <= lo_d;
            right_out       <= ro_d;
            burst_q         <= burst_d;
            stop_q          <= stop_d;
        end
    end

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Self-checking bench for audio_rec_play_ctrl with a behavioural
// single-port RAM of RD_LAT read latency.
module tb_audio_rec_play_ctrl;

    localparam int SW  = 16;
    localparam int AW  = 3;
    localparam int REP = 3;
    localparam int RDL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rec_start, play_start, stop, loop_en, passthrough;
    logic          av, al;
    logic [SW-1:0] left_in, right_in;
    logic          read_audio_in, write_audio_out;
    logic [SW-1:0] left_out, right_out;
    logic [AW-1:0] mem_addr;
    logic [2*SW-1:0] mem_wdata, mem_rdata;
    logic          mem_wren;
    logic [AW:0]   rec_len;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_rec_play_ctrl #(
        .SAMPLE_W(SW), .ADDR_W(AW), .REPEAT(REP), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst),
        .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .loop_en(loop_en), .passthrough(passthrough),
        .audio_in_available(av), .audio_out_allowed(al),
        .left_in(left_in), .right_in(right_in),
        .read_audio_in(read_audio_in), .write_audio_out(write_audio_out),
        .left_out(left_out), .right_out(right_out),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata), .rec_len(rec_len), .state(state)
    );

    // RAM model and write log
    logic [2*SW-1:0] ram [2**AW];
    logic [2*SW-1:0] pipe [RDL];
    logic [AW-1:0]   wa [64];
    logic [2*SW-1:0] wd [64];
    int nw = 0;

    assign mem_rdata = pipe[RDL-1];

    always @(posedge clk) begin
        if (mem_wren) begin
            ram[mem_addr] <= mem_wdata;
            if (nw < 64) begin
                wa[nw] <= mem_addr;
                wd[nw] <= mem_wdata;
                nw     <= nw + 1;
            end
        end
        pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int max,
                              input string name);
        int n = 0;
        while (state !== exp && n < max) begin
            step();
            n++;
        end
        check(name, state, exp);
    endtask

    task automatic feed(input logic [SW-1:0] l, input logic [SW-1:0] r);
        av = 1'b1; al = 1'b1; left_in = l; right_in = r;
        step();
        av = 1'b0; al = 1'b0;
    endtask

    typedef struct {
        logic          pt, av, al;
        logic [SW-1:0] l, r;
        logic          e_rd, e_wr;
        logic [SW-1:0] e_l, e_r;
    } pvec_t;

    pvec_t tbl[8];
    logic [2*SW-1:0] exp_data[6];
    int ns, c, base, cnt;
    logic prev;

    initial begin
        tbl[0] = '{1, 1, 1, 16'h1234, 16'h5678, 1, 1, 16'h1234, 16'h5678};
        tbl[1] = '{1, 1, 1, 16'h1111, 16'h2222, 0, 0, 16'h1234, 16'h5678};
        tbl[2] = '{1, 1, 1, 16'h9ABC, 16'hDEF0, 1, 1, 16'h9ABC, 16'hDEF0};
        tbl[3] = '{1, 1, 0, 16'h3333, 16'h4444, 0, 0, 16'h9ABC, 16'hDEF0};
        tbl[4] = '{1, 0, 1, 16'h3333, 16'h4444, 0, 0, 16'h9ABC, 16'hDEF0};
        tbl[5] = '{0, 1, 1, 16'h5555, 16'h6666, 0, 0, 16'h0000, 16'h0000};
        tbl[6] = '{0, 1, 1, 16'h7777, 16'h8888, 0, 0, 16'h0000, 16'h0000};
        tbl[7] = '{1, 0, 0, 16'h9999, 16'hAAAA, 0, 0, 16'h0000, 16'h0000};
        exp_data = '{32'hAAAABBBB, 32'hAAAABBBB, 32'hAAAABBBB,
                     32'hCCCCDDDD, 32'hCCCCDDDD, 32'hCCCCDDDD};

        rst = 1'b0; rec_start = 0; play_start = 0; stop = 0;
        loop_en = 0; passthrough = 0; av = 0; al = 0;
        left_in = '0; right_in = '0;
        step(); step();
        check("rst_state", state, 0);
        check("rst_len", rec_len, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_strobes", {read_audio_in, write_audio_out}, 0);
        check("rst_out", {left_out, right_out}, 0);
        check("rst_wdata", mem_wdata, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            passthrough = tbl[i].pt; av = tbl[i].av; al = tbl[i].al;
            left_in = tbl[i].l; right_in = tbl[i].r;
            step();
            check($sformatf("pt%0d_rd", i), read_audio_in, tbl[i].e_rd);
            check($sformatf("pt%0d_wr", i), write_audio_out, tbl[i].e_wr);
            check($sformatf("pt%0d_l", i), left_out, tbl[i].e_l);
            check($sformatf("pt%0d_r", i), right_out, tbl[i].e_r);
            check($sformatf("pt%0d_st", i), state, 0);
        end
        passthrough = 0; av = 0; al = 0;
        step();

        play_start = 1; step(); play_start = 0;
        check("play_empty_state", state, 0);
        check("play_empty_wr", write_audio_out, 0);

        // record two samples; stop arrives mid-burst and is deferred
        rec_start = 1; play_start = 1; step();
        rec_start = 0; play_start = 0;
        check("rec_wins", state, 1);
        step();
        check("rec_no_go_rd", read_audio_in, 0);
        feed(16'hAAAA, 16'hBBBB);
        check("rec_rd", read_audio_in, 1);
        check("rec_wren", mem_wren, 1);
        check("rec_state_wr", state, 2);
        step();
        check("rec_rd_once", read_audio_in, 0);
        wait_state(1, 10, "rec_back_wait");
        feed(16'hCCCC, 16'hDDDD);
        stop = 1; step(); stop = 0;
        check("rec_stop_pending", state, 2);
        wait_state(0, 10, "rec_stop_idle");
        check("rec_nw", nw, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rec_a%0d", i), wa[i], i);
            check($sformatf("rec_d%0d", i), wd[i], exp_data[i]);
        end
        check("rec_len6", rec_len, 6);

        // one-shot playback with continuous go
        av = 1; al = 1;
        play_start = 1; step(); play_start = 0;
        check("play_state", state, 3);
        ns = 0; prev = 0;
        for (int cc = 2; cc <= 36; cc++) begin
            step();
            if (write_audio_out) begin
                if (ns < 6) begin
                    check("play_data", {left_out, right_out}, exp_data[ns]);
                    check("play_time", cc, 5 + 4 * ns);
                    check("play_rd", read_audio_in, 1);
                end
                check("play_gap", prev, 0);
                ns++;
            end
            prev = write_audio_out;
        end
        check("play_count", ns, 6);
        check("play_end_state", state, 0);
        check("play_end_out", {left_out, right_out}, 0);

        // looped playback, then stop during fetch
        loop_en = 1;
        play_start = 1; step(); play_start = 0;
        ns = 0; c = 0;
        while (ns < 7 && c < 60) begin
            step();
            c++;
            if (write_audio_out) begin
                check("loop_data", {left_out, right_out}, exp_data[ns % 6]);
                ns++;
            end
        end
        check("loop_count", ns, 7);
        wait_state(4, 8, "loop_fetch");
        stop = 1; step(); stop = 0;
        check("stop_state", state, 0);
        check("stop_strobes", {read_audio_in, write_audio_out}, 0);
        check("stop_out", {left_out, right_out}, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (write_audio_out) cnt++;
        end
        check("stop_quiet", cnt, 0);
        loop_en = 0; av = 0; al = 0;
        step();

        // memory full: last burst truncated, no wrap
        base = nw;
        rec_start = 1; step(); rec_start = 0;
        feed(16'h1111, 16'h2222);
        wait_state(1, 10, "full_w1");
        feed(16'h3333, 16'h4444);
        wait_state(1, 10, "full_w2");
        feed(16'h5555, 16'h6666);
        wait_state(0, 10, "full_idle");
        check("full_len", rec_len, 8);
        check("full_nw", nw - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_a%0d", i), wa[base+i], i);
            check($sformatf("full_d%0d", i), wd[base+i],
                  i < 3 ? 32'h11112222 : (i < 6 ? 32'h33334444 : 32'h55556666));
        end
        repeat (5) step();
        check("full_no_wrap", nw - base, 8);

        // asynchronous reset in the middle of a burst
        rec_start = 1; step(); rec_start = 0;
        feed(16'h1357, 16'h2468);
        check("ar_wren", mem_wren, 1);
        step();
        check("ar_len_pre", rec_len, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_wren0", mem_wren, 0);
        check("ar_len0", rec_len, 0);
        check("ar_state", state, 0);
        step();
        rst = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
